// File: rtl/mem_access_ctrl_if.sv
// Load/store request channel plus the 16-bit data memory pins.
// The controller takes the slave view; the execute stage / memory side takes master.
interface mem_access_ctrl_if;
  // request from execute stage
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_size;
  logic        req_signed;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  // completion back to execute stage
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  // data memory port
  logic        wmem;
  logic [15:0] DAddress;
  logic [15:0] DataIn;
  logic        memc;
  logic [15:0] DataOut;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, DataOut,
    output req_ready, resp_valid, resp_rdata, resp_err, wmem, DAddress, DataIn, memc
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, DataOut,
    input  req_ready, resp_valid, resp_rdata, resp_err, wmem, DAddress, DataIn, memc
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// CPU-side initiator for the 16-bit big-endian data memory.
// One request in flight; odd-address halfwords become two byte accesses because
// the memory drops address bit 0 on halfword access.
module mem_access_ctrl #(
  parameter int MEM_BYTES        = 64,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_ctrl_if.slave bus
);

  localparam logic [1:0]  IDLE    = 2'd0;
  localparam logic [1:0]  ISSUE1  = 2'd1;
  localparam logic [1:0]  ISSUE2  = 2'd2;
  localparam logic [1:0]  CAPTURE = 2'd3;
  // 17 bits so the compare holds for any MEM_BYTES up to the full 64K space
  localparam logic [16:0] LIMIT   = 17'(MEM_BYTES);

  typedef struct packed {
    logic        write;
    logic        size;
    logic        sgn;
    logic        split;
    logic [15:0] addr;
    logic [15:0] wdata;
  } req_t;

  logic [1:0]  state, state_nxt;
  req_t        rq;
  logic [7:0]  hi_byte;
  logic        acc, misal, oob, rej, last_issue;
  logic [15:0] addr_p1, load_data;
  logic        resp_valid_q, resp_err_q;
  logic [15:0] resp_rdata_q;
  logic        wmem, memc;
  logic [15:0] daddr, din;

  assign bus.req_ready = (state == IDLE);
  assign acc           = bus.req_valid && (state == IDLE);

  // Range check covers both bytes of a halfword; the +1 wraps at 16 bits.
  assign addr_p1 = bus.req_addr + 16'd1;
  assign misal   = bus.req_size && bus.req_addr[0];
  assign oob     = ({1'b0, bus.req_addr} >= LIMIT) ||
                   (bus.req_size && ({1'b0, addr_p1} >= LIMIT));
  assign rej     = oob || (misal && !SPLIT_MISALIGNED);

  // The edge leaving this state completes the memory side of a store.
  assign last_issue = ((state == ISSUE1) && !rq.split) || (state == ISSUE2);

  // Next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc && !rej) state_nxt = ISSUE1;
      ISSUE1:  state_nxt = rq.split ? ISSUE2 : (rq.write ? IDLE : CAPTURE);
      ISSUE2:  state_nxt = rq.write ? IDLE : CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any access in flight without a response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Latch the request on the accept edge only; req_* is don't-care otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq <= '0;
    end else if (acc) begin
      rq.write <= bus.req_write;
      rq.size  <= bus.req_size;
      rq.sgn   <= bus.req_signed;
      rq.split <= misal;
      rq.addr  <= bus.req_addr;
      rq.wdata <= bus.req_wdata;
    end
  end

  // First (high) byte of a split load shows up on DataOut during ISSUE2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            hi_byte <= 8'h00;
    else if ((state == ISSUE2) && !rq.write) hi_byte <= bus.DataOut[7:0];
  end

  // Shape the load result from the final read beat
  always_comb begin
    load_data = 16'h0000;
    if (rq.split)     load_data = {hi_byte, bus.DataOut[7:0]};
    else if (rq.size) load_data = bus.DataOut;
    else if (rq.sgn)  load_data = {{8{bus.DataOut[7]}}, bus.DataOut[7:0]};
    else              load_data = {8'h00, bus.DataOut[7:0]};
  end

  // One-cycle completion pulse; data and error are zero unless qualified
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 16'h0000;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 16'h0000;
      if (acc && rej) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= 1'b1;
      end else if (last_issue && rq.write) begin
        resp_valid_q <= 1'b1;
      end else if (state == CAPTURE) begin
        resp_valid_q <= 1'b1;
        resp_rdata_q <= load_data;
      end
    end
  end

  // Memory pins: quiet in IDLE/CAPTURE, big-endian byte split in ISSUE1/ISSUE2
  always_comb begin
    wmem  = 1'b0;
    memc  = 1'b0;
    daddr = 16'h0000;
    din   = 16'h0000;
    case (state)
      ISSUE1: begin
        wmem  = rq.write;
        daddr = rq.addr;
        if (rq.split) begin
          din = {8'h00, rq.wdata[15:8]};
        end else if (rq.size) begin
          memc = 1'b1;
          din  = rq.wdata;
        end else begin
          din = {8'h00, rq.wdata[7:0]};
        end
      end
      ISSUE2: begin
        wmem  = rq.write;
        daddr = rq.addr + 16'd1;
        din   = {8'h00, rq.wdata[7:0]};
      end
      default: ;
    endcase
  end

  assign bus.wmem       = wmem;
  assign bus.memc       = memc;
  assign bus.DAddress   = daddr;
  assign bus.DataIn     = din;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule
